// File: rtl/mem_pkg.sv
// Shared types for the data-RAM access path: request opcodes, FSM states,
// byte/half lane selectors and opcode classification helpers.
package mem_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_RMW_WR = 3'd3,
        ST_WR     = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

    // Byte lanes are little-endian: lane 0 is bits [7:0].
    localparam logic [1:0] LANE_B0 = 2'd0;
    localparam logic [1:0] LANE_B1 = 2'd1;
    localparam logic [1:0] LANE_B2 = 2'd2;
    localparam logic [1:0] LANE_B3 = 2'd3;
    localparam logic       LANE_H0 = 1'b0;
    localparam logic       LANE_H1 = 1'b1;

    function automatic logic is_store(input op_t op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic logic is_half(input op_t op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

    function automatic logic is_word(input op_t op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: extracts a sign/zero-extended load result from a
// RAM word, and merges sub-word store data into a RAM word for read-modify-write.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  lane_i,
    input  op_t         op_i,
    output logic [31:0] extract_o,
    output logic [31:0] merge_o
);

    function automatic logic [31:0] extract(input logic [31:0] word,
                                            input logic [1:0]  lane,
                                            input op_t         op);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            LANE_B0: b = word[7:0];
            LANE_B1: b = word[15:8];
            LANE_B2: b = word[23:16];
            default: b = word[31:24];
        endcase
        h = (lane[1] == LANE_H1) ? word[31:16] : word[15:0];
        case (op)
            OP_LW:   r = word;
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'h0000, h};
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'h000000, b};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] word,
                                          input logic [31:0] wdata,
                                          input logic [1:0]  lane,
                                          input op_t         op);
        logic [31:0] m;
        m = word;
        if (op == OP_SB) begin
            case (lane)
                LANE_B0: m[7:0]   = wdata[7:0];
                LANE_B1: m[15:8]  = wdata[7:0];
                LANE_B2: m[23:16] = wdata[7:0];
                default: m[31:24] = wdata[7:0];
            endcase
        end else if (op == OP_SH) begin
            if (lane[1] == LANE_H0) begin
                m[15:0] = wdata[15:0];
            end else begin
                m[31:16] = wdata[15:0];
            end
        end
        return m;
    endfunction

    assign extract_o = extract(word_i, lane_i, op_i);
    assign merge_o   = merge(word_i, wdata_i, lane_i, op_i);

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side load/store initiator for a word-wide little-endian RAM. Sub-word stores
// are done as read-modify-write; misaligned or out-of-range requests are trapped.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int MEM_BYTES = 100
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  op_t         req_op_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    input  logic [31:0] mem_rdata_i
);

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] extract_word;
    logic [31:0] merge_word;
    logic        addr_bad;
    logic [32:0] last_byte;

    mem_lane_align u_align (
        .word_i    (mem_rdata_i),
        .wdata_i   (wdata_q),
        .lane_i    (addr_q[1:0]),
        .op_i      (op_q),
        .extract_o (extract_word),
        .merge_o   (merge_word)
    );

    // Range test on the whole word touched; 33 bits so addresses near 2^32 cannot wrap.
    assign last_byte = {1'b0, req_addr_i[31:2], 2'b00} + 33'd3;
    assign addr_bad  = (is_half(req_op_i) && req_addr_i[0])
                    || (is_word(req_op_i) && (req_addr_i[1:0] != 2'b00))
                    || (last_byte >= 33'(MEM_BYTES));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LW;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            merge_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        merge_d = merge_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    op_d    = req_op_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    err_d   = addr_bad;
                    if (addr_bad) begin
                        rdata_d = 32'h0;
                        state_d = ST_RESP;
                    end else if (req_op_i == OP_SW) begin
                        state_d = ST_WR;
                    end else if (is_store(req_op_i)) begin
                        state_d = ST_RMW_RD;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                rdata_d = extract_word;
                state_d = ST_RESP;
            end
            ST_WR: begin
                rdata_d = 32'h0;
                state_d = ST_RESP;
            end
            ST_RMW_RD: begin
                // Hold the already-merged word so the write phase drives a register.
                merge_d = merge_word;
                state_d = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                rdata_d = 32'h0;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready_o  = (state_q == ST_IDLE);
        resp_valid_o = (state_q == ST_RESP);
        resp_err_o   = (state_q == ST_RESP) && err_q;
        resp_rdata_o = rdata_q;
        mem_addr_o   = {addr_q[31:2], 2'b00};
        mem_read_o   = (state_q == ST_RD) || (state_q == ST_RMW_RD);
        mem_write_o  = (state_q == ST_WR) || (state_q == ST_RMW_WR);
        case (state_q)
            ST_WR:     mem_wdata_o = wdata_q;
            ST_RMW_WR: mem_wdata_o = merge_q;
            default:   mem_wdata_o = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit against a small word RAM model; each
// request is checked for latency, strobes, result and error flag.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    op_t         req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    logic [31:0] ram [0:31];
    logic        pl_en = 1'b0;
    logic [4:0]  pl_idx = 5'd0;
    logic [31:0] pl_data = 32'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_BYTES(100)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_read_o   (mem_read),
        .mem_write_o  (mem_write),
        .mem_rdata_i  (mem_rdata)
    );

    assign mem_rdata = ram[mem_addr[6:2]];

    always @(posedge clk) begin
        if (mem_write) ram[mem_addr[6:2]] <= mem_wdata;
        else if (pl_en) ram[pl_idx] <= pl_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [4:0] idx, input logic [31:0] data);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_data = data;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic xfer(input string tag, input op_t op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_lat,
                        input int exp_rd, input int exp_wr);
        int lat, nrd, nwr, both, first_rd, first_wr;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1; nrd = 0; nwr = 0; both = 0; first_rd = 0; first_wr = 0;
        while (!resp_valid && lat < 10) begin
            if (mem_read)  begin nrd++; if (first_rd == 0) first_rd = lat; end
            if (mem_write) begin nwr++; if (first_wr == 0) first_wr = lat; end
            if (mem_read && mem_write) both++;
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".rdata"}, resp_rdata, exp_rdata);
        chk({tag, ".err"}, 32'(resp_err), 32'(exp_err));
        chk({tag, ".reads"}, 32'(nrd), 32'(exp_rd));
        chk({tag, ".writes"}, 32'(nwr), 32'(exp_wr));
        chk({tag, ".overlap"}, 32'(both), 32'd0);
        if (exp_rd > 0 && exp_wr > 0)
            chk({tag, ".rd_before_wr"}, 32'(first_rd < first_wr), 32'd1);
        @(negedge clk);
        chk({tag, ".pulse"}, 32'(resp_valid), 32'd0);
        $display("txn %-8s op=%0d addr=0x%08h rdata=0x%08h err=%0b lat=%0d",
                 tag, op, addr, resp_rdata, exp_err, lat);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        req_valid = 1'b0; req_op = OP_LW; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst.ready", 32'(req_ready), 32'd1);
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.resp_err", 32'(resp_err), 32'd0);
        chk("rst.resp_rdata", resp_rdata, 32'h0);
        chk("rst.strobes", {30'h0, mem_read, mem_write}, 32'h0);
        chk("rst.mem_addr", mem_addr, 32'h0);
        chk("rst.mem_wdata", mem_wdata, 32'h0);
        reset = 1'b0;

        preload(5'd2, 32'h8899AABB);
        preload(5'd3, 32'h11223344);
        preload(5'd5, 32'hCAFEF00D);
        preload(5'd24, 32'h0BADC0DE);

        xfer("LB9",   OP_LB,  32'd9,  32'h0, 32'hFFFFFFAA, 1'b0, 2, 1, 0);
        xfer("LBU9",  OP_LBU, 32'd9,  32'h0, 32'h000000AA, 1'b0, 2, 1, 0);
        xfer("LB11",  OP_LB,  32'd11, 32'h0, 32'hFFFFFF88, 1'b0, 2, 1, 0);
        xfer("LH10",  OP_LH,  32'd10, 32'h0, 32'hFFFF8899, 1'b0, 2, 1, 0);
        xfer("LHU10", OP_LHU, 32'd10, 32'h0, 32'h00008899, 1'b0, 2, 1, 0);
        xfer("LH8",   OP_LH,  32'd8,  32'h0, 32'hFFFFAABB, 1'b0, 2, 1, 0);
        xfer("LW8",   OP_LW,  32'd8,  32'h0, 32'h8899AABB, 1'b0, 2, 1, 0);

        xfer("SB13",  OP_SB,  32'd13, 32'h55, 32'h0, 1'b0, 3, 1, 1);
        chk("SB13.ram", ram[3], 32'h11225544);
        xfer("SH14",  OP_SH,  32'd14, 32'hFFFF7766, 32'h0, 1'b0, 3, 1, 1);
        chk("SH14.ram", ram[3], 32'h77665544);

        xfer("SH3",   OP_SH,  32'd3,   32'h1234, 32'h0, 1'b1, 1, 0, 0);
        xfer("LW6",   OP_LW,  32'd6,   32'h0,    32'h0, 1'b1, 1, 0, 0);
        xfer("LW96",  OP_LW,  32'd96,  32'h0,    32'h0BADC0DE, 1'b0, 2, 1, 0);
        xfer("LW100", OP_LW,  32'd100, 32'h0,    32'h0, 1'b1, 1, 0, 0);
        xfer("SB101", OP_SB,  32'd101, 32'h0,    32'h0, 1'b1, 1, 0, 0);

        // Reset in the middle of an RMW write phase.
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_SB; req_addr = 32'd20; req_wdata = 32'h77;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!mem_write && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rstmid.reached_wr", 32'(mem_write), 32'd1);
        reset = 1'b1;
        #1;
        chk("rstmid.write_drop", 32'(mem_write), 32'd0);
        chk("rstmid.read_drop", 32'(mem_read), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rstmid.ram", ram[5], 32'hCAFEF00D);
        chk("rstmid.ready", 32'(req_ready), 32'd1);
        chk("rstmid.resp_valid", 32'(resp_valid), 32'd0);
        $display("txn RSTMID   op=%0d addr=0x%08h ram=0x%08h", OP_SB, 32'd20, ram[5]);

        // Back-to-back SW then LW with req_valid held throughout.
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_SW; req_addr = 32'd0; req_wdata = 32'hDEADBEEF;
        chk("b2b.ready0", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_op = OP_LW; req_wdata = 32'h0;
        chk("b2b.busy_wr", 32'(req_ready), 32'd0);
        chk("b2b.sw_write", 32'(mem_write), 32'd1);
        @(negedge clk);
        chk("b2b.sw_resp", 32'(resp_valid), 32'd1);
        chk("b2b.busy_resp", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("b2b.ready1", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b.lw_read", 32'(mem_read), 32'd1);
        @(negedge clk);
        chk("b2b.lw_resp", 32'(resp_valid), 32'd1);
        chk("b2b.lw_rdata", resp_rdata, 32'hDEADBEEF);
        chk("b2b.lw_err", 32'(resp_err), 32'd0);
        chk("b2b.ram", ram[0], 32'hDEADBEEF);
        $display("txn B2B      SW/LW addr=0x00000000 rdata=0x%08h", resp_rdata);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
